// File: rtl/reg_master_arb_pkg.sv
// Shared definitions for the register-bus master arbiter: FSM encoding,
// abort read data and the width helper used to size counters and indices.
package reg_master_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Also what the group decoder returns for unmapped selects.
    localparam logic [31:0] REG_TIMEOUT_DATA = 32'hDEAD_BEEF;

    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_rr_pick.sv
// Combinational round-robin selector: rotates the request vector so the
// pointer lands at bit 0, then picks the lowest set bit.
module reg_rr_pick
    import reg_master_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic                   valid,
    output logic [IDX_W-1:0]       grant
);

    logic [2*NUM_MASTERS-1:0] doubled;
    logic [NUM_MASTERS-1:0]   rotated;
    int                       offset;
    int                       sum;

    always_comb begin
        doubled = {req, req};
        rotated = NUM_MASTERS'(doubled >> ptr);
        valid   = |req;
        offset  = 0;
        // Scan downward so the lowest set bit (closest to the pointer) wins.
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = i;
            end
        end
        sum = int'(ptr) + offset;
        if (sum >= NUM_MASTERS) begin
            sum = sum - NUM_MASTERS;
        end
        grant = IDX_W'(sum);
    end

endmodule

// File: rtl/reg_master_arb.sv
// Round-robin arbiter placing one upstream register master at a time onto the
// downstream register bus, with a per-transaction timeout and stray-ack flag.
module reg_master_arb
    import reg_master_arb_pkg::*;
#(
    parameter int NUM_MASTERS   = 2,
    parameter int REG_ADDR_BITS = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_rd_wr_L,
    input  logic [NUM_MASTERS*REG_ADDR_BITS-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wr_data,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [DATA_WIDTH-1:0]             m_rd_data,
    output logic                              reg_req,
    output logic                              reg_rd_wr_L,
    output logic [REG_ADDR_BITS-1:0]          reg_addr,
    output logic [DATA_WIDTH-1:0]             reg_wr_data,
    input  logic                              reg_ack,
    input  logic [DATA_WIDTH-1:0]             reg_rd_data,
    output logic                              timeout_err,
    output logic                              stray_ack_err
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? log2_ceil(NUM_MASTERS) : 1;
    localparam int CNT_W = log2_ceil(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(REG_TIMEOUT_DATA);

    arb_state_t               state, state_n;
    logic [IDX_W-1:0]         grant_q, grant_n;
    logic [IDX_W-1:0]         ptr_q, ptr_n;
    logic [IDX_W-1:0]         pick_grant;
    logic                     pick_valid;
    logic [CNT_W-1:0]         cnt_q, cnt_n;

    logic                     reg_req_n;
    logic                     reg_rd_wr_L_n;
    logic [REG_ADDR_BITS-1:0] reg_addr_n;
    logic [DATA_WIDTH-1:0]    reg_wr_data_n;
    logic [NUM_MASTERS-1:0]   m_ack_n;
    logic [DATA_WIDTH-1:0]    m_rd_data_n;
    logic                     timeout_err_n;
    logic                     stray_ack_err_n;

    logic [REG_ADDR_BITS-1:0] addr_arr  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]    wdata_arr [NUM_MASTERS];

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            addr_arr[i]  = m_addr[i*REG_ADDR_BITS +: REG_ADDR_BITS];
            wdata_arr[i] = m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    reg_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .req   (m_req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .grant (pick_grant)
    );

    // Next values for every registered output, so all outputs leave flops.
    always_comb begin
        state_n         = state;
        grant_n         = grant_q;
        ptr_n           = ptr_q;
        cnt_n           = cnt_q;
        reg_req_n       = reg_req;
        reg_rd_wr_L_n   = reg_rd_wr_L;
        reg_addr_n      = reg_addr;
        reg_wr_data_n   = reg_wr_data;
        m_ack_n         = '0;
        m_rd_data_n     = m_rd_data;
        timeout_err_n   = 1'b0;
        stray_ack_err_n = reg_ack && (state != BUSY);

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    reg_req_n     = 1'b1;
                    reg_rd_wr_L_n = m_rd_wr_L[pick_grant];
                    reg_addr_n    = addr_arr[pick_grant];
                    reg_wr_data_n = wdata_arr[pick_grant];
                    grant_n       = pick_grant;
                    cnt_n         = '0;
                    state_n       = BUSY;
                end
            end
            BUSY: begin
                cnt_n = cnt_q + CNT_W'(1);
                // A real ack wins over a timeout landing in the same cycle.
                if (reg_ack) begin
                    m_rd_data_n       = reg_rd_data;
                    reg_req_n         = 1'b0;
                    m_ack_n[grant_q]  = 1'b1;
                    state_n           = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    m_rd_data_n       = TIMEOUT_DATA;
                    reg_req_n         = 1'b0;
                    m_ack_n[grant_q]  = 1'b1;
                    timeout_err_n     = 1'b1;
                    state_n           = RESP;
                end
            end
            RESP: begin
                if (NUM_MASTERS == 1 || int'(grant_q) == NUM_MASTERS - 1) begin
                    ptr_n = '0;
                end else begin
                    ptr_n = grant_q + IDX_W'(1);
                end
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            grant_q       <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            reg_req       <= 1'b0;
            reg_rd_wr_L   <= 1'b0;
            reg_addr      <= '0;
            reg_wr_data   <= '0;
            m_ack         <= '0;
            m_rd_data     <= '0;
            timeout_err   <= 1'b0;
            stray_ack_err <= 1'b0;
        end else begin
            state         <= state_n;
            grant_q       <= grant_n;
            ptr_q         <= ptr_n;
            cnt_q         <= cnt_n;
            reg_req       <= reg_req_n;
            reg_rd_wr_L   <= reg_rd_wr_L_n;
            reg_addr      <= reg_addr_n;
            reg_wr_data   <= reg_wr_data_n;
            m_ack         <= m_ack_n;
            m_rd_data     <= m_rd_data_n;
            timeout_err   <= timeout_err_n;
            stray_ack_err <= stray_ack_err_n;
        end
    end

endmodule

// File: tb/tb_reg_master_arb.sv
// Scoreboard bench for reg_master_arb: expected grants and responses are queued
// as requests are driven and checked as the downstream bus and m_ack fire.
module tb_reg_master_arb;
    import reg_master_arb_pkg::*;

    localparam int NM = 2;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NM-1:0]    m_req;
    logic [NM-1:0]    m_rd_wr_L;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wr_data;
    logic [NM-1:0]    m_ack;
    logic [DW-1:0]    m_rd_data;
    logic             reg_req;
    logic             reg_rd_wr_L;
    logic [AW-1:0]    reg_addr;
    logic [DW-1:0]    reg_wr_data;
    logic             reg_ack;
    logic [DW-1:0]    reg_rd_data;
    logic             timeout_err;
    logic             stray_ack_err;

    reg_master_arb #(
        .NUM_MASTERS   (NM),
        .REG_ADDR_BITS (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT       (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m_req         (m_req),
        .m_rd_wr_L     (m_rd_wr_L),
        .m_addr        (m_addr),
        .m_wr_data     (m_wr_data),
        .m_ack         (m_ack),
        .m_rd_data     (m_rd_data),
        .reg_req       (reg_req),
        .reg_rd_wr_L   (reg_rd_wr_L),
        .reg_addr      (reg_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_ack       (reg_ack),
        .reg_rd_data   (reg_rd_data),
        .timeout_err   (timeout_err),
        .stray_ack_err (stray_ack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
        logic          rd_wr_L;
        logic [DW-1:0] wdata;
        int            len;
        logic [DW-1:0] rdata;
        logic          tout;
    } txn_t;

    txn_t req_q[$];
    txn_t rsp_q[$];
    txn_t req_cur;
    txn_t rsp_e;

    int            checks = 0;
    int            errors = 0;
    int            ack_count = 0;
    int            stray_count = 0;
    int            tout_count = 0;
    int            busy_len = 0;
    logic          prev_req = 1'b0;
    int            slave_ack_cycle = 0;
    logic [DW-1:0] slave_data = '0;
    int            stray_req_cnt = 0;
    bit            abort_expected = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [AW-1:0] addr,
                                 input logic rdwr, input logic [DW-1:0] wdata);
        m_addr[idx*AW +: AW]    = addr;
        m_rd_wr_L[idx]          = rdwr;
        m_wr_data[idx*DW +: DW] = wdata;
        m_req[idx]              = 1'b1;
    endtask

    task automatic pushTxn(input int idx, input logic [AW-1:0] addr, input logic rdwr,
                           input logic [DW-1:0] wdata, input int len,
                           input logic [DW-1:0] rdata, input logic tout, input bit with_rsp);
        txn_t t;
        t.idx     = idx;
        t.addr    = addr;
        t.rd_wr_L = rdwr;
        t.wdata   = wdata;
        t.len     = len;
        t.rdata   = rdata;
        t.tout    = tout;
        req_q.push_back(t);
        if (with_rsp) begin
            rsp_q.push_back(t);
        end
    endtask

    // Returns one cycle after the RESP cycle, i.e. where masters drop m_req.
    task automatic waitAcks(input int target, input int budget);
        int n;
        n = 0;
        while (ack_count < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (ack_count < target) begin
            checkOutput("ack_wait", 64'(ack_count), 64'(target));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitReq(input int budget);
        int n;
        n = 0;
        while (!reg_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!reg_req) begin
            checkOutput("req_wait", 64'(reg_req), 64'(1));
        end
    endtask

    // Downstream slave: acks on a programmable BUSY cycle, plus injected stray acks.
    initial begin : slave
        int busy_cnt;
        int stray_done;
        busy_cnt    = 0;
        stray_done  = 0;
        reg_ack     = 1'b0;
        reg_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            reg_ack     = 1'b0;
            reg_rd_data = '0;
            if (stray_done != stray_req_cnt) begin
                stray_done++;
                reg_ack     = 1'b1;
                reg_rd_data = 32'h0BAD_0BAD;
            end else if (reg_req) begin
                busy_cnt++;
                if (slave_ack_cycle > 0 && busy_cnt == slave_ack_cycle) begin
                    reg_ack     = 1'b1;
                    reg_rd_data = slave_data;
                end
            end else begin
                busy_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (timeout_err) tout_count++;
        if (stray_ack_err) stray_count++;
        if (m_ack != '0) begin
            ack_count++;
            if (rsp_q.size() == 0) begin
                checkOutput("unexpected_ack", 64'(m_ack), 64'(0));
            end else begin
                rsp_e = rsp_q.pop_front();
                checkOutput("m_ack_vec", 64'(m_ack), 64'(1) << rsp_e.idx);
                checkOutput("m_rd_data", 64'(m_rd_data), 64'(rsp_e.rdata));
                checkOutput("timeout_err", 64'(timeout_err), 64'(rsp_e.tout));
            end
        end
    end

    always @(negedge clk) begin
        if (reg_req && !prev_req) begin
            busy_len = 1;
            if (req_q.size() == 0) begin
                checkOutput("unexpected_req", 64'(reg_req), 64'(0));
                req_cur.addr    = reg_addr;
                req_cur.rd_wr_L = reg_rd_wr_L;
                req_cur.wdata   = reg_wr_data;
                req_cur.len     = 0;
            end else begin
                req_cur = req_q.pop_front();
            end
        end else if (reg_req) begin
            busy_len++;
        end else if (prev_req && !abort_expected) begin
            checkOutput("busy_len", 64'(busy_len), 64'(req_cur.len));
        end
        if (reg_req) begin
            checkOutput("reg_addr", 64'(reg_addr), 64'(req_cur.addr));
            checkOutput("reg_rd_wr_L", 64'(reg_rd_wr_L), 64'(req_cur.rd_wr_L));
            checkOutput("reg_wr_data", 64'(reg_wr_data), 64'(req_cur.wdata));
        end
        prev_req = reg_req;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_ack;
        int base_stray;
        reset     = 1'b1;
        m_req     = '0;
        m_rd_wr_L = '0;
        m_addr    = '0;
        m_wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_m_ack", 64'(m_ack), 64'(0));
        checkOutput("rst_reg_req", 64'(reg_req), 64'(0));
        checkOutput("rst_reg_addr", 64'(reg_addr), 64'(0));
        checkOutput("rst_reg_wr_data", 64'(reg_wr_data), 64'(0));
        checkOutput("rst_reg_rd_wr_L", 64'(reg_rd_wr_L), 64'(0));
        checkOutput("rst_m_rd_data", 64'(m_rd_data), 64'(0));
        checkOutput("rst_timeout_err", 64'(timeout_err), 64'(0));
        checkOutput("rst_stray_ack_err", 64'(stray_ack_err), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] contention: both masters held, expect 0,1,0,1");
        slave_ack_cycle = 2;
        slave_data      = 32'h0000_1111;
        for (int k = 0; k < 4; k++) begin
            pushTxn(k % 2, (k % 2) ? 10'h020 : 10'h010, 1'b1, '0, 2, 32'h0000_1111, 1'b0, 1'b1);
        end
        base_ack = ack_count;
        applyStimulus(0, 10'h010, 1'b1, '0);
        applyStimulus(1, 10'h020, 1'b1, '0);
        waitAcks(base_ack + 4, 100);
        m_req = '0;

        $display("[TB] single read from master 0");
        slave_ack_cycle = 4;
        slave_data      = 32'h1234_5678;
        pushTxn(0, 10'h004, 1'b1, '0, 4, 32'h1234_5678, 1'b0, 1'b1);
        base_ack = ack_count;
        applyStimulus(0, 10'h004, 1'b1, '0);
        waitAcks(base_ack + 1, 40);
        m_req[0] = 1'b0;

        $display("[TB] write pass-through from master 1 with inputs changing");
        slave_ack_cycle = 6;
        slave_data      = 32'h5555_AAAA;
        pushTxn(1, 10'h3F0, 1'b0, 32'hCAFE_0001, 6, 32'h5555_AAAA, 1'b0, 1'b1);
        base_ack = ack_count;
        applyStimulus(1, 10'h3F0, 1'b0, 32'hCAFE_0001);
        repeat (3) @(posedge clk);
        #1;
        m_wr_data[DW +: DW] = 32'hFFFF_FFFF;
        m_addr[AW +: AW]    = 10'h001;
        m_rd_wr_L[1]        = 1'b1;
        waitAcks(base_ack + 1, 40);
        m_req[1] = 1'b0;

        $display("[TB] timeout from master 0");
        slave_ack_cycle = 0;
        pushTxn(0, 10'h055, 1'b1, '0, TO, REG_TIMEOUT_DATA, 1'b1, 1'b1);
        base_ack = ack_count;
        applyStimulus(0, 10'h055, 1'b1, '0);
        waitAcks(base_ack + 1, 60);
        m_req[0] = 1'b0;

        $display("[TB] late ack after timeout");
        repeat (5) @(posedge clk);
        #1;
        base_ack   = ack_count;
        base_stray = stray_count;
        stray_req_cnt++;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("stray_pulses", 64'(stray_count - base_stray), 64'(1));
        checkOutput("late_no_m_ack", 64'(ack_count), 64'(base_ack));
        checkOutput("late_rd_data", 64'(m_rd_data), 64'(REG_TIMEOUT_DATA));
        checkOutput("late_no_req", 64'(reg_req), 64'(0));

        $display("[TB] reset during BUSY");
        pushTxn(1, 10'h1AB, 1'b1, '0, 0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1, 10'h1AB, 1'b1, '0);
        waitReq(10);
        repeat (3) @(posedge clk);
        #1;
        abort_expected = 1'b1;
        reset          = 1'b1;
        m_req          = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("abort_reg_req", 64'(reg_req), 64'(0));
        checkOutput("abort_m_ack", 64'(m_ack), 64'(0));
        checkOutput("abort_timeout_err", 64'(timeout_err), 64'(0));
        abort_expected = 1'b0;

        $display("[TB] pointer back at master 0 after reset");
        slave_ack_cycle = 1;
        slave_data      = 32'h0000_2222;
        pushTxn(0, 10'h0C0, 1'b1, '0, 1, 32'h0000_2222, 1'b0, 1'b1);
        pushTxn(1, 10'h0C1, 1'b1, '0, 1, 32'h0000_2222, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        base_ack = ack_count;
        applyStimulus(0, 10'h0C0, 1'b1, '0);
        applyStimulus(1, 10'h0C1, 1'b1, '0);
        waitAcks(base_ack + 2, 40);
        m_req = '0;

        repeat (5) @(negedge clk);
        #1;
        checkOutput("rsp_q_left", 64'(rsp_q.size()), 64'(0));
        checkOutput("req_q_left", 64'(req_q.size()), 64'(0));
        checkOutput("timeout_pulses", 64'(tout_count), 64'(1));
        checkOutput("total_acks", 64'(ack_count), 64'(9));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
